// File: rtl/bool_sweep_checker.sv
// Exhaustive sweeper/checker for an N_IN-input, single-output combinational block.
// Drives every input vector in binary order and compares the sampled response with a latched truth table.
module bool_sweep_checker #(
  parameter int unsigned N_IN  = 3,
  parameter int unsigned HOLD  = 4,
  parameter int unsigned CNT_W = N_IN + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 continuous_i,
  input  logic [2**N_IN-1:0]   exp_tt_i,
  input  logic                 dut_out_i,
  output logic [N_IN-1:0]      vec_out_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [CNT_W-1:0]     err_cnt_o,
  output logic [N_IN-1:0]      first_err_vec_o,
  output logic                 first_err_valid_o
);

  localparam int unsigned NVEC = 2 ** N_IN;
  // Keep the hold counter at least one bit wide so HOLD=1 still elaborates.
  localparam int unsigned HW   = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {StIdle, StDrive, StDone} state_e;

  state_e            state_q;
  logic [NVEC-1:0]   tt_q;
  logic [HW-1:0]     hold_q;
  logic [N_IN-1:0]   vec_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [CNT_W-1:0]  err_cnt_q;
  logic [CNT_W-1:0]  err_cnt_d;
  logic [N_IN-1:0]   first_err_vec_q;
  logic              first_err_valid_q;

  logic sample;
  logic mismatch;
  logic last_vec;

  always_comb begin
    sample    = (state_q == StDrive) && (hold_q == HW'(HOLD - 1));
    mismatch  = sample && (dut_out_i != tt_q[vec_q]);
    last_vec  = (vec_q == {N_IN{1'b1}});
    err_cnt_d = err_cnt_q;
    if (mismatch && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q           <= StIdle;
      tt_q              <= '0;
      hold_q            <= '0;
      vec_q             <= '0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      pass_q            <= 1'b0;
      err_cnt_q         <= '0;
      first_err_vec_q   <= '0;
      first_err_valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_i && (state_q != StIdle)) begin
        // Results of the cancelled sweep stay visible.
        state_q <= StIdle;
        vec_q   <= '0;
        hold_q  <= '0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            vec_q  <= '0;
            busy_q <= 1'b0;
            if (start_i) begin
              tt_q              <= exp_tt_i;
              err_cnt_q         <= '0;
              first_err_vec_q   <= '0;
              first_err_valid_q <= 1'b0;
              hold_q            <= '0;
              busy_q            <= 1'b1;
              state_q           <= StDrive;
            end
          end
          StDrive: begin
            err_cnt_q <= err_cnt_d;
            if (mismatch && !first_err_valid_q) begin
              first_err_vec_q   <= vec_q;
              first_err_valid_q <= 1'b1;
            end
            if (sample) begin
              hold_q <= '0;
              if (last_vec) begin
                vec_q   <= '0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                pass_q  <= (err_cnt_d == '0);
                state_q <= StDone;
              end else begin
                vec_q <= vec_q + 1'b1;
              end
            end else begin
              hold_q <= hold_q + 1'b1;
            end
          end
          StDone: begin
            if (continuous_i) begin
              tt_q              <= exp_tt_i;
              err_cnt_q         <= '0;
              first_err_vec_q   <= '0;
              first_err_valid_q <= 1'b0;
              hold_q            <= '0;
              vec_q             <= '0;
              busy_q            <= 1'b1;
              state_q           <= StDrive;
            end else begin
              state_q <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign vec_out_o         = vec_q;
  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign pass_o            = pass_q;
  assign err_cnt_o         = err_cnt_q;
  assign first_err_vec_o   = first_err_vec_q;
  assign first_err_valid_o = first_err_valid_q;

endmodule

// File: tb/tb_bool_sweep_checker.sv
// Directed bench for bool_sweep_checker: table-driven sweeps on the default build plus
// hand-written continuous, abort, reset and small-parameter sequences.
module tb_bool_sweep_checker;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, abort, cont;
  logic [7:0] tt;
  logic       dut;
  logic [2:0] vec;
  logic       busy, done, pass;
  logic [3:0] err;
  logic [2:0] fvec;
  logic       fval;
  int         mode;

  // mode 0: XOR DUT, mode 1: output stuck at 0
  assign dut = (mode == 0) ? ^vec : 1'b0;

  bool_sweep_checker #(.N_IN(3), .HOLD(4), .CNT_W(4)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort), .continuous_i(cont),
    .exp_tt_i(tt), .dut_out_i(dut), .vec_out_o(vec), .busy_o(busy), .done_o(done),
    .pass_o(pass), .err_cnt_o(err), .first_err_vec_o(fvec), .first_err_valid_o(fval)
  );

  logic       s_start, s_mode, s_dut;
  logic [3:0] s_tt;
  logic [1:0] s_vec, s_fvec;
  logic       s_busy, s_done, s_pass, s_fval;
  logic [0:0] s_err;

  // Small build: 2-input AND, or its complement when s_mode=1
  assign s_dut = s_mode ? ~(&s_vec) : (&s_vec);

  bool_sweep_checker #(.N_IN(2), .HOLD(1), .CNT_W(1)) u_small (
    .clk_i(clk), .rst_ni(rst_n), .start_i(s_start), .abort_i(1'b0), .continuous_i(1'b0),
    .exp_tt_i(s_tt), .dut_out_i(s_dut), .vec_out_o(s_vec), .busy_o(s_busy),
    .done_o(s_done), .pass_o(s_pass), .err_cnt_o(s_err), .first_err_vec_o(s_fvec),
    .first_err_valid_o(s_fval)
  );

  typedef struct {
    int         mode;
    logic [7:0] tt;
    int         err;
    int         fvec;
    int         fval;
    int         pass;
  } vec_t;

  vec_t tbl[6];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a sweep; t counts cycles after the edge that captures start.
  task automatic run_sweep(output int busy_cyc, output int done_at, output int vec_bad);
    logic [7:0] tt_save;
    tt_save  = tt;
    busy_cyc = 0;
    done_at  = -1;
    vec_bad  = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int t = 0; t < 80; t++) begin
      if (t == 7)  start = 1'b1;
      if (t == 8)  start = 1'b0;
      if (t == 10) tt = ~tt_save;
      if (busy) begin
        busy_cyc++;
        if (vec != 3'(t / 4)) vec_bad++;
      end
      if (done) begin
        done_at = t;
        break;
      end
      step();
    end
    tt = tt_save;
  endtask

  task automatic run_small(output int busy_cyc, output int done_at);
    busy_cyc = 0;
    done_at  = -1;
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (s_busy) busy_cyc++;
      if (s_done) begin
        done_at = t;
        break;
      end
      step();
    end
  endtask

  initial begin
    int bc, da, vb, nd;
    bit seen;

    tbl[0] = '{mode: 0, tt: 8'h96, err: 0, fvec: 0, fval: 0, pass: 1};
    tbl[1] = '{mode: 1, tt: 8'h96, err: 4, fvec: 1, fval: 1, pass: 0};
    tbl[2] = '{mode: 1, tt: 8'h00, err: 0, fvec: 0, fval: 0, pass: 1};
    tbl[3] = '{mode: 1, tt: 8'hFF, err: 8, fvec: 0, fval: 1, pass: 0};
    tbl[4] = '{mode: 0, tt: 8'h69, err: 8, fvec: 0, fval: 1, pass: 0};
    tbl[5] = '{mode: 0, tt: 8'h80, err: 3, fvec: 1, fval: 1, pass: 0};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; cont = 1'b0; tt = 8'h96; mode = 0;
    s_start = 1'b0; s_mode = 1'b0; s_tt = 4'b1000;
    repeat (3) step();
    chk("rst_vec", int'(vec), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_fval", int'(fval), 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      mode = tbl[i].mode;
      tt   = tbl[i].tt;
      run_sweep(bc, da, vb);
      chk($sformatf("t%0d_busy_cycles", i), bc, 32);
      chk($sformatf("t%0d_done_at", i), da, 32);
      chk($sformatf("t%0d_vec_seq", i), vb, 0);
      chk($sformatf("t%0d_err", i), int'(err), tbl[i].err);
      chk($sformatf("t%0d_fvec", i), int'(fvec), tbl[i].fvec);
      chk($sformatf("t%0d_fval", i), int'(fval), tbl[i].fval);
      chk($sformatf("t%0d_pass", i), int'(pass), tbl[i].pass);
      step();
      chk($sformatf("t%0d_idle_busy", i), int'(busy), 0);
      chk($sformatf("t%0d_idle_done", i), int'(done), 0);
    end

    // Continuous: failing sweep, then passing sweep restarted with no idle gap
    mode = 1; tt = 8'h96; cont = 1'b1; nd = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int t = 0; t < 140; t++) begin
      if (done) nd++;
      if (t == 32) begin
        chk("cont_done1", int'(done), 1);
        chk("cont_err1", int'(err), 4);
        chk("cont_pass1", int'(pass), 0);
        mode = 0;
      end
      if (t == 33) begin
        chk("cont_restart_busy", int'(busy), 1);
        chk("cont_restart_err", int'(err), 0);
        chk("cont_restart_fval", int'(fval), 0);
        chk("cont_pass_kept", int'(pass), 0);
        cont = 1'b0;
      end
      if (t == 65) begin
        chk("cont_done2", int'(done), 1);
        chk("cont_err2", int'(err), 0);
        chk("cont_pass2", int'(pass), 1);
      end
      if (t == 66) begin
        chk("cont_idle_busy", int'(busy), 0);
        break;
      end
      step();
    end
    chk("cont_done_count", nd, 2);

    // Abort when vector 5 is driven: v1, v2, v4 already failed
    mode = 1; tt = 8'h96; seen = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int t = 0; t < 60; t++) begin
      if (vec == 3'd5) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk("abort_reached_v5", int'(seen), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_vec", int'(vec), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_err", int'(err), 3);
    chk("abort_fvec", int'(fvec), 1);
    chk("abort_fval", int'(fval), 1);
    chk("abort_pass_kept", int'(pass), 1);
    nd = 0;
    repeat (40) begin
      if (done || busy) nd++;
      step();
    end
    chk("abort_quiet", nd, 0);

    // Asynchronous reset between edges mid-sweep
    mode = 0; tt = 8'h96;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_vec", int'(vec), 0);
    chk("arst_pass", int'(pass), 0);
    chk("arst_err", int'(err), 0);
    chk("arst_fval", int'(fval), 0);
    step();
    rst_n = 1'b1;
    step();
    run_sweep(bc, da, vb);
    chk("arst_resweep_done_at", da, 32);
    chk("arst_resweep_vec_seq", vb, 0);
    chk("arst_resweep_pass", int'(pass), 1);
    step();

    // Small build: HOLD=1, N_IN=2, CNT_W=1
    s_mode = 1'b0; s_tt = 4'b1000;
    run_small(bc, da);
    chk("small_busy_cycles", bc, 4);
    chk("small_done_at", da, 4);
    chk("small_pass", int'(s_pass), 1);
    chk("small_err", int'(s_err), 0);
    step();
    s_mode = 1'b1;
    run_small(bc, da);
    chk("small_bad_done_at", da, 4);
    chk("small_bad_err_sat", int'(s_err), 1);
    chk("small_bad_pass", int'(s_pass), 0);
    chk("small_bad_fvec", int'(s_fvec), 0);
    chk("small_bad_fval", int'(s_fval), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
